// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: single-cycle ALU ops plus an iterative one-bit-per-cycle
// shifter, with a valid/ready handshake on both the request and result sides.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_ctrl,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal,
    output logic        busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shkind_t;

    state_t      state_q, state_d;
    shkind_t     kind_q, kind_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  count_q, count_d;
    logic        sign_q, sign_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        illegal_q, illegal_d;
    logic        out_valid_q, out_valid_d;

    logic [31:0] alu_res;
    logic        alu_ill;
    logic        is_shift;
    shkind_t     kind_new;
    logic [4:0]  shamt;
    logic [31:0] step;
    logic        accept;

    assign shamt     = src_b[4:0];
    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == SHIFT);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    // Decode the request and compute the single-cycle result; shifts yield src_a,
    // which is the correct answer only for a zero shift amount.
    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        kind_new = SH_LL;
        case (alu_ctrl)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = src_a & src_b;
            4'b0011: alu_res = src_a | src_b;
            4'b0100: alu_res = src_a ^ src_b;
            4'b0101: alu_res = {31'b0, ($signed(src_a) < $signed(src_b))};
            4'b0110: begin
                is_shift = 1'b1;
                kind_new = SH_LL;
                alu_res  = src_a;
            end
            4'b0111: begin
                is_shift = 1'b1;
                kind_new = SH_RL;
                alu_res  = src_a;
            end
            4'b1000: begin
                is_shift = 1'b1;
                kind_new = SH_RA;
                alu_res  = src_a;
            end
            4'b1001: alu_res = {31'b0, (src_a < src_b)};
            default: alu_ill = 1'b1;
        endcase
    end

    // One-bit shift of the work register; arithmetic fill uses the sign captured at accept.
    always_comb begin
        case (kind_q)
            SH_LL:   step = {work_q[30:0], 1'b0};
            SH_RL:   step = {1'b0, work_q[31:1]};
            default: step = {sign_q, work_q[31:1]};
        endcase
    end

    // Next-state logic: accept requests in IDLE, iterate shifts in SHIFT, manage result handshake.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        work_d      = work_q;
        count_d     = count_q;
        sign_d      = sign_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != 5'd0)) begin
                        work_d  = src_a;
                        count_d = shamt;
                        kind_d  = kind_new;
                        sign_d  = src_a[31];
                        state_d = SHIFT;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == 32'd0);
                        illegal_d   = alu_ill;
                        out_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                work_d  = step;
                count_d = count_q - 5'd1;
                if (count_q == 5'd1) begin
                    result_d    = step;
                    zero_d      = (step == 32'd0);
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any shift in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kind_q      <= SH_LL;
            work_q      <= '0;
            count_q     <= '0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            work_q      <= work_d;
            count_q     <= count_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl against a behavioural reference model.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: {illegal, result} straight from the operation definitions.
    function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ill;
        int          sh;
        sh  = int'(b % 32);
        ill = 1'b0;
        r   = 32'd0;
        case (c)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = a << sh;
            4'd7: r = a >> sh;
            4'd8: r = $signed(a) >>> sh;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: begin
                r   = 32'd0;
                ill = 1'b1;
            end
        endcase
        return {ill, r};
    endfunction

    function automatic int model_latency(input logic [3:0] c, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        if ((c == 4'd6 || c == 4'd7 || c == 4'd8) && sh != 0) return sh + 1;
        return 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with out_ready=1 and check latency, busy profile and the delivered result.
    task automatic issue_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [32:0] exp;
        int          exp_lat;
        int          lat;
        exp     = model(c, a, b);
        exp_lat = model_latency(c, b);
        in_valid  = 1'b1;
        alu_ctrl  = c;
        src_a     = a;
        src_b     = b;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL %s in_ready before accept: got %b expected 1", tag, in_ready);
        end
        tick();
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL %s shifting busy/in_ready: got %b/%b expected 1/0", tag, busy, in_ready);
            end
            tick();
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            fails++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
        end
        checks++;
        if (result !== exp[31:0] || zero !== (exp[31:0] == 32'd0) || illegal !== exp[32]) begin
            fails++;
            $display("[TB] FAIL %s result/zero/illegal: got %h/%b/%b expected %h/%b/%b",
                     tag, result, zero, illegal, exp[31:0], (exp[31:0] == 32'd0), exp[32]);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s busy after result: got %b expected 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctrl  = 4'd0;
        src_a     = 32'd0;
        src_b     = 32'd0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset outputs: got v=%b r=%h z=%b i=%b b=%b expected all 0",
                     out_valid, result, zero, illegal, busy);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset in_ready: got %b expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_add_wrap();
        issue_op(4'b0000, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        checks++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            fails++;
            $display("[TB] FAIL add_wrap const: got %h/%b expected 00000000/1", result, zero);
        end
    endtask

    task automatic test_sra();
        issue_op(4'b1000, 32'h8000_0000, 32'd4, "sra4");
        checks++;
        if (result !== 32'hF800_0000) begin
            fails++;
            $display("[TB] FAIL sra4 const: got %h expected f8000000", result);
        end
    endtask

    task automatic test_compare_illegal();
        issue_op(4'b0101, 32'hFFFF_FFFF, 32'd1, "slt");
        checks++;
        if (result !== 32'd1) begin
            fails++;
            $display("[TB] FAIL slt const: got %h expected 00000001", result);
        end
        issue_op(4'b1001, 32'hFFFF_FFFF, 32'd1, "sltu");
        checks++;
        if (result !== 32'd0) begin
            fails++;
            $display("[TB] FAIL sltu const: got %h expected 00000000", result);
        end
        issue_op(4'b1100, $urandom, $urandom, "illegal");
    endtask

    task automatic test_shamt_zero();
        issue_op(4'b0111, 32'hA5A5_1234, 32'h0000_0020, "srl_shamt0");
    endtask

    task automatic test_backpressure();
        logic [32:0] exp1;
        logic [32:0] exp2;
        logic [31:0] a;
        logic [31:0] b;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        a    = $urandom;
        b    = $urandom;
        exp1 = model(4'd4, a, b);
        in_valid  = 1'b1;
        alu_ctrl  = 4'd4;
        src_a     = a;
        src_b     = b;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== exp1[31:0] || in_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL backpressure hold %0d: got v=%b r=%h rdy=%b expected 1/%h/0",
                         k, out_valid, result, in_ready, exp1[31:0]);
            end
            tick();
        end
        a    = $urandom;
        b    = $urandom;
        exp2 = model(4'd0, a, b);
        in_valid  = 1'b1;
        alu_ctrl  = 4'd0;
        src_a     = a;
        src_b     = b;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL backpressure release in_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== exp2[31:0]) begin
            fails++;
            $display("[TB] FAIL backpressure reload: got v=%b r=%h expected 1/%h", out_valid, result, exp2[31:0]);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL backpressure drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_pending_during_shift();
        logic [32:0] exp_sh;
        logic [32:0] exp_add;
        logic [31:0] a;
        logic [31:0] a2;
        logic [31:0] b2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        a      = $urandom;
        a2     = $urandom;
        b2     = $urandom;
        exp_sh = model(4'd7, a, 32'd3);
        exp_add = model(4'd0, a2, b2);
        in_valid = 1'b1;
        alu_ctrl = 4'd7;
        src_a    = a;
        src_b    = 32'd3;
        tick();
        alu_ctrl = 4'd0;
        src_a    = a2;
        src_b    = b2;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL pending cycle %0d: got v=%b busy=%b rdy=%b expected 0/1/0", k, out_valid, busy, in_ready);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || result !== exp_sh[31:0] || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL pending shift result: got v=%b r=%h rdy=%b expected 1/%h/1",
                     out_valid, result, in_ready, exp_sh[31:0]);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== exp_add[31:0]) begin
            fails++;
            $display("[TB] FAIL pending accepted: got v=%b r=%h expected 1/%h", out_valid, result, exp_add[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c = 4'($urandom_range(0, 15));
            if (c == 4'd6 || c == 4'd7 || c == 4'd8) c = 4'd3;
            a   = $urandom;
            b   = $urandom;
            exp = model(c, a, b);
            in_valid = 1'b1;
            alu_ctrl = c;
            src_a    = a;
            src_b    = b;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("[TB] FAIL back_to_back %0d in_ready: got %b expected 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== exp[31:0] || illegal !== exp[32]) begin
                fails++;
                $display("[TB] FAIL back_to_back %0d: got v=%b r=%h i=%b expected 1/%h/%b",
                         i, out_valid, result, illegal, exp[31:0], exp[32]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_shift();
        logic [32:0] exp;
        logic [31:0] a;
        logic [31:0] b;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        alu_ctrl = 4'd6;
        src_a    = $urandom | 32'h1;
        src_b    = 32'd31;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_shift reset outputs: got v=%b r=%h z=%b i=%b b=%b expected all 0",
                     out_valid, result, zero, illegal, busy);
        end
        tick();
        rst_n = 1'b1;
        a   = $urandom;
        b   = $urandom;
        exp = model(4'd0, a, b);
        in_valid = 1'b1;
        alu_ctrl = 4'd0;
        src_a    = a;
        src_b    = b;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_shift release in_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== exp[31:0]) begin
            fails++;
            $display("[TB] FAIL mid_shift add after release: got v=%b r=%h expected 1/%h", out_valid, result, exp[31:0]);
        end
        for (int k = 0; k < 35; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("[TB] FAIL mid_shift stray result cycle %0d: got v=%b busy=%b expected 0/0", k, out_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  c;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 15));
            b = $urandom;
            if (i % 3 == 0) c = 4'(6 + (i % 9) / 3);
            issue_op(c, $urandom, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_sra();
        test_compare_illegal();
        test_shamt_zero();
        test_backpressure();
        test_pending_during_shift();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
